// File: rtl/dma_multichannel_ctrl_if.sv
// Purpose : bundle of command, bus-arbitration, memory-write and device-read
//           signals for the multi-channel DMA controller.
// Latency : n/a (wires only).
// Backpressure: cmd_ready per channel; bus ownership via br/bg.
// Ports (master = DMA side):
//   in : cmd_valid, cmd_addr, cmd_len, bg, dev_data
//   out: cmd_ready, br, mem_write, mem_addr, mem_data, dev_ch, dev_offset,
//        done_int, busy
interface dma_multichannel_ctrl_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_CH     = 2,
  parameter int LEN_W      = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]                cmd_valid;
  logic [NUM_CH-1:0]                cmd_ready;
  logic [NUM_CH*WORD_SIZE-1:0]      cmd_addr;
  logic [NUM_CH*LEN_W-1:0]          cmd_len;
  logic                             br;
  logic                             bg;
  logic                             mem_write;
  logic [WORD_SIZE-1:0]             mem_addr;
  logic [LINE_WORDS*WORD_SIZE-1:0]  mem_data;
  logic [CH_W-1:0]                  dev_ch;
  logic [LEN_W-1:0]                 dev_offset;
  logic [LINE_WORDS*WORD_SIZE-1:0]  dev_data;
  logic [NUM_CH-1:0]                done_int;
  logic                             busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, bg, dev_data,
    output cmd_ready, br, mem_write, mem_addr, mem_data, dev_ch, dev_offset,
           done_int, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, bg, dev_data,
    input  cmd_ready, br, mem_write, mem_addr, mem_data, dev_ch, dev_offset,
           done_int, busy
  );
endinterface

// File: rtl/dma_multichannel_ctrl.sv
// Purpose : multi-channel DMA; round-robin picks a pending channel, requests
//           the data bus (br/bg), writes device lines into memory, and pulses
//           a per-channel done interrupt.
// Latency : 1 (IDLE->REQ) + grant latency + len*WR_CYCLES + 1 + release latency.
// Backpressure: cmd_ready[i] low while channel i pending; losing bg mid-transfer
//           freezes counters and gates mem_write until bg returns.
// Ports   : clk, reset_n (synchronous, active-low), bus (master modport).
module dma_multichannel_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_CH     = 2,
  parameter int LEN_W      = 8,
  parameter int WR_CYCLES  = 2
) (
  input logic                     clk,
  input logic                     reset_n,
  dma_multichannel_ctrl_if.master bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WC_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t                          state;
  logic [NUM_CH-1:0]               pending;
  logic [WORD_SIZE-1:0]            ch_addr [NUM_CH];
  logic [LEN_W-1:0]                ch_len  [NUM_CH];
  logic [CH_W-1:0]                 rr;
  logic [CH_W-1:0]                 cur;
  logic [WORD_SIZE-1:0]            cur_addr;
  logic [LEN_W-1:0]                cur_len;
  logic [LEN_W-1:0]                line_cnt;
  logic [WC_W-1:0]                 wr_cnt;
  logic                            br_q;
  logic [NUM_CH-1:0]               done_q;
  logic [WORD_SIZE-1:0]            addr_hold;
  logic [LINE_WORDS*WORD_SIZE-1:0] data_hold;

  logic [NUM_CH-1:0]               accept;
  logic [NUM_CH-1:0]               zl_mask;
  logic [NUM_CH-1:0]               go_mask;
  logic [NUM_CH-1:0]               done_nxt;
  logic [CH_W-1:0]                 pick;
  logic                            pick_vld;
  logic                            in_xfer;
  logic                            wr_last;
  logic                            line_last;
  logic [WORD_SIZE-1:0]            line_addr;

  always_comb begin
    accept  = bus.cmd_valid & ~pending;
    zl_mask = '0;
    go_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      zl_mask[i] = pending[i] && (ch_len[i] == '0);
      go_mask[i] = pending[i] && (ch_len[i] != '0);
    end
  end

  // Round-robin: scan from rr+NUM_CH down to rr+1 so the channel nearest
  // after rr overwrites any farther candidate.
  always_comb begin
    pick     = rr;
    pick_vld = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (go_mask[(int'(rr) + k) % NUM_CH]) begin
        pick     = CH_W'((int'(rr) + k) % NUM_CH);
        pick_vld = 1'b1;
      end
    end
  end

  // Zero-length commands complete straight from IDLE; a transfer completes
  // once the CPU has taken the bus back.
  always_comb begin
    done_nxt = '0;
    if (state == IDLE) begin
      done_nxt = zl_mask;
    end else if (state == REL && !bus.bg) begin
      done_nxt[cur] = 1'b1;
    end
  end

  assign in_xfer   = (state == XFER);
  assign wr_last   = (wr_cnt == WC_W'(WR_CYCLES - 1));
  assign line_last = (line_cnt == cur_len - LEN_W'(1));
  assign line_addr = cur_addr + WORD_SIZE'(line_cnt) * WORD_SIZE'(LINE_WORDS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pending   <= '0;
      rr        <= CH_W'(NUM_CH - 1);
      cur       <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      line_cnt  <= '0;
      wr_cnt    <= '0;
      br_q      <= 1'b0;
      done_q    <= '0;
      addr_hold <= '0;
      data_hold <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_addr[i] <= '0;
        ch_len[i]  <= '0;
      end
    end else begin
      done_q  <= done_nxt;
      // Set and clear never hit the same bit: accept needs !pending.
      pending <= (pending & ~done_nxt) | accept;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) begin
          ch_addr[i] <= bus.cmd_addr[i*WORD_SIZE +: WORD_SIZE];
          ch_len[i]  <= bus.cmd_len[i*LEN_W +: LEN_W];
        end
      end
      // Shadow the live bus so mem_addr/mem_data hold once XFER ends.
      if (in_xfer) begin
        addr_hold <= line_addr;
        data_hold <= bus.dev_data;
      end

      case (state)
        IDLE: begin
          if (zl_mask == '0 && pick_vld) begin
            cur      <= pick;
            rr       <= pick;
            cur_addr <= ch_addr[pick];
            cur_len  <= ch_len[pick];
            line_cnt <= '0;
            wr_cnt   <= '0;
            br_q     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.bg) state <= XFER;
        end
        XFER: begin
          // Counters only advance on granted cycles; bg low = preemption.
          if (bus.bg) begin
            if (wr_last) begin
              wr_cnt <= '0;
              if (line_last) begin
                br_q  <= 1'b0;
                state <= REL;
              end else begin
                line_cnt <= line_cnt + 1'b1;
              end
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        REL: begin
          if (!bus.bg) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = ~pending;
  assign bus.br         = br_q;
  assign bus.mem_write  = in_xfer & bus.bg;
  assign bus.mem_addr   = in_xfer ? line_addr : addr_hold;
  assign bus.mem_data   = in_xfer ? bus.dev_data : data_hold;
  assign bus.dev_ch     = cur;
  assign bus.dev_offset = line_cnt;
  assign bus.done_int   = done_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_dma_multichannel_ctrl.sv
// Purpose : self-checking bench for dma_multichannel_ctrl; expected line
//           writes and done pulses are queued when commands are issued and
//           popped by a monitor as the DUT produces them.
// Latency : n/a.  Backpressure: bg follows br one cycle later unless blocked.
module tb_dma_multichannel_ctrl;
  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_CH     = 2;
  localparam int LEN_W      = 8;
  localparam int WR_CYCLES  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic bg_block = 1'b0;
  logic br_seen = 1'b0;

  always #5 clk = ~clk;

  dma_multichannel_ctrl_if #(
    .WORD_SIZE(WORD_SIZE), .LINE_WORDS(LINE_WORDS), .NUM_CH(NUM_CH), .LEN_W(LEN_W)
  ) bus ();

  dma_multichannel_ctrl #(
    .WORD_SIZE(WORD_SIZE), .LINE_WORDS(LINE_WORDS), .NUM_CH(NUM_CH),
    .LEN_W(LEN_W), .WR_CYCLES(WR_CYCLES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int wr_total = 0;
  int done_total = 0;

  typedef struct {
    logic [15:0] addr;
    int          ch;
    int          off;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];

  function automatic logic [63:0] dev_model(input int ch, input int off);
    logic [63:0] d;
    for (int k = 0; k < LINE_WORDS; k++) d[k*16 +: 16] = {4'(ch), 4'(k), 8'(off)};
    return d;
  endfunction

  assign bus.dev_data = dev_model(int'(bus.dev_ch), int'(bus.dev_offset));

  // CPU model: grants one cycle after br, releases one cycle after br drops.
  initial begin
    bus.bg = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.bg  = br_seen & ~bg_block;
      br_seen = bus.br;
    end
  end

  // Scoreboard monitor.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.mem_write === 1'b1) begin
          wr_total++;
          n_cmp++;
          if (exp_wr.size() == 0) begin
            n_err++;
            $display("FAIL write_unexpected: got write addr=%h ch=%0d, expected no write",
                     bus.mem_addr, bus.dev_ch);
          end else begin
            e = exp_wr.pop_front();
            if (bus.mem_addr !== e.addr || bus.dev_offset !== 8'(e.off) ||
                bus.dev_ch !== 1'(e.ch) || bus.mem_data !== dev_model(e.ch, e.off)) begin
              n_err++;
              $display("FAIL write_line: got addr=%h off=%0d ch=%0d data=%h, expected addr=%h off=%0d ch=%0d data=%h",
                       bus.mem_addr, bus.dev_offset, bus.dev_ch, bus.mem_data,
                       e.addr, e.off, e.ch, dev_model(e.ch, e.off));
            end
          end
        end
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.done_int[c] === 1'b1) begin
            done_total++;
            n_cmp++;
            if (exp_done.size() == 0) begin
              n_err++;
              $display("FAIL done_unexpected: got done_int[%0d], expected none", c);
            end else if (exp_done[0] != c || bus.cmd_ready[c] !== 1'b1 ||
                         bus.br !== 1'b0 || bus.bg !== 1'b0) begin
              n_err++;
              $display("FAIL done_pulse: got ch=%0d ready=%b br=%b bg=%b, expected ch=%0d ready=1 br=0 bg=0",
                       c, bus.cmd_ready[c], bus.br, bus.bg, exp_done[0]);
              void'(exp_done.pop_front());
            end else begin
              void'(exp_done.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_expect(input int ch, input logic [15:0] addr, input int len);
    wr_t e;
    for (int l = 0; l < len; l++) begin
      for (int w = 0; w < WR_CYCLES; w++) begin
        e.addr = addr + 16'(l * LINE_WORDS);
        e.ch   = ch;
        e.off  = l;
        exp_wr.push_back(e);
      end
    end
    exp_done.push_back(ch);
  endtask

  task automatic send_cmds(input logic [1:0] mask, input logic [15:0] a0, input int l0,
                           input logic [15:0] a1, input int l1);
    @(posedge clk);
    #1;
    bus.cmd_addr  = {a1, a0};
    bus.cmd_len   = {8'(l1), 8'(l0)};
    bus.cmd_valid = mask;
    n_cmp++;
    if ((bus.cmd_ready & mask) !== mask) begin
      n_err++;
      $display("FAIL cmd_ready_before_send: got %b, expected ready for %b", bus.cmd_ready, mask);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = '0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(bus.busy === 1'b0 && bus.cmd_ready === 2'b11 &&
                 exp_wr.size() == 0 && exp_done.size() == 0) && cyc < 300);
    n_cmp++;
    if (cyc >= 300) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d writes / %0d dones still outstanding, expected 0",
               name, exp_wr.size(), exp_done.size());
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp += 8;
    if (bus.br !== 1'b0)         begin n_err++; $display("FAIL rst_br: got %b, expected 0", bus.br); end
    if (bus.mem_write !== 1'b0)  begin n_err++; $display("FAIL rst_mem_write: got %b, expected 0", bus.mem_write); end
    if (bus.mem_addr !== 16'h0)  begin n_err++; $display("FAIL rst_mem_addr: got %h, expected 0", bus.mem_addr); end
    if (bus.dev_ch !== 1'b0)     begin n_err++; $display("FAIL rst_dev_ch: got %b, expected 0", bus.dev_ch); end
    if (bus.dev_offset !== 8'h0) begin n_err++; $display("FAIL rst_dev_offset: got %h, expected 0", bus.dev_offset); end
    if (bus.done_int !== 2'b00)  begin n_err++; $display("FAIL rst_done_int: got %b, expected 00", bus.done_int); end
    if (bus.cmd_ready !== 2'b11) begin n_err++; $display("FAIL rst_cmd_ready: got %b, expected 11", bus.cmd_ready); end
    if (bus.busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    int w0, d0;
    w0 = wr_total;
    d0 = done_total;
    push_expect(0, 16'h01F0, 3);
    send_cmds(2'b01, 16'h01F0, 3, 16'h0, 0);
    wait_idle("basic");
    n_cmp += 2;
    if (wr_total - w0 != 6)   begin n_err++; $display("FAIL basic_write_cycles: got %0d, expected 6", wr_total - w0); end
    if (done_total - d0 != 1) begin n_err++; $display("FAIL basic_done_count: got %0d, expected 1", done_total - d0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_expect(0, 16'h0300, 1);
      push_expect(1, 16'h0400, 1);
      send_cmds(2'b11, 16'h0300, 1, 16'h0400, 1);
      wait_idle("rr_order");
    end
  endtask

  task automatic test_preempt();
    int w0, d0, cyc;
    w0 = wr_total;
    d0 = done_total;
    push_expect(0, 16'h0100, 2);
    send_cmds(2'b01, 16'h0100, 2, 16'h0, 0);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (wr_total - w0 < 2 && cyc < 100);
    n_cmp++;
    if (cyc >= 100) begin
      n_err++;
      $display("FAIL preempt_start_timeout: got %0d writes, expected 2", wr_total - w0);
    end
    bg_block = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.mem_write !== 1'b0 || bus.mem_addr !== 16'h0104 ||
          bus.dev_offset !== 8'd1 || bus.br !== 1'b1) begin
        n_err++;
        $display("FAIL preempt_frozen: got we=%b addr=%h off=%0d br=%b, expected we=0 addr=0104 off=1 br=1",
                 bus.mem_write, bus.mem_addr, bus.dev_offset, bus.br);
      end
    end
    bg_block = 1'b0;
    wait_idle("preempt");
    n_cmp += 2;
    if (wr_total - w0 != 4)   begin n_err++; $display("FAIL preempt_write_cycles: got %0d, expected 4", wr_total - w0); end
    if (done_total - d0 != 1) begin n_err++; $display("FAIL preempt_done_count: got %0d, expected 1", done_total - d0); end
  endtask

  task automatic test_zero_len();
    logic saw_br;
    push_expect(1, 16'h0500, 0);
    send_cmds(2'b10, 16'h0, 0, 16'h0500, 0);
    saw_br = bus.br;
    @(negedge clk);
    n_cmp++;
    if (bus.done_int !== 2'b00) begin n_err++; $display("FAIL zl_early_done: got %b, expected 00", bus.done_int); end
    @(negedge clk);
    n_cmp++;
    if (bus.done_int !== 2'b10 || bus.cmd_ready !== 2'b11) begin
      n_err++;
      $display("FAIL zl_done: got done=%b ready=%b, expected done=10 ready=11", bus.done_int, bus.cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_br = saw_br | bus.br;
    end
    n_cmp++;
    if (saw_br !== 1'b0) begin n_err++; $display("FAIL zl_br: got %b, expected 0", saw_br); end
    wait_idle("zero_len");
  endtask

  task automatic test_addr_wrap();
    push_expect(0, 16'hFFFC, 2);
    send_cmds(2'b01, 16'hFFFC, 2, 16'h0, 0);
    wait_idle("addr_wrap");
  endtask

  task automatic test_reset_abort();
    int w0, d0, cyc;
    w0 = wr_total;
    push_expect(1, 16'h0200, 4);
    send_cmds(2'b10, 16'h0, 0, 16'h0200, 4);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (wr_total - w0 < 2 && cyc < 100);
    n_cmp++;
    if (cyc >= 100) begin
      n_err++;
      $display("FAIL abort_start_timeout: got %0d writes, expected 2", wr_total - w0);
    end
    reset_n = 1'b0;
    @(negedge clk);
    exp_wr.delete();
    exp_done.delete();
    d0 = done_total;
    n_cmp++;
    if (bus.br !== 1'b0 || bus.mem_write !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 2'b11) begin
      n_err++;
      $display("FAIL abort_state: got br=%b we=%b busy=%b ready=%b, expected 0 0 0 11",
               bus.br, bus.mem_write, bus.busy, bus.cmd_ready);
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp += 2;
    if (done_total != d0) begin n_err++; $display("FAIL abort_no_done: got %0d dones, expected 0", done_total - d0); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: got busy=%b, expected 0", bus.busy); end
  endtask

  initial begin
    bus.cmd_valid = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_preempt();
    test_zero_len();
    test_addr_wrap();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
